// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU ops, result classes, multiplier FSM states.
// The iterative multiplier behind them is compiled only when EX_MUL_EN is defined.
package ex_stage_pkg;

    localparam logic [7:0] EXE_NOP_OP   = 8'b00000000;
    localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
    localparam logic [7:0] EXE_LUI_OP   = 8'b01011100;
    localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b00000011;
    localparam logic [7:0] EXE_MOVZ_OP  = 8'b00001010;
    localparam logic [7:0] EXE_MOVN_OP  = 8'b00001011;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;

    localparam logic [5:0] EXE_MULT  = 6'b011000;
    localparam logic [5:0] EXE_MULTU = 6'b011001;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;

    localparam logic [1:0] MUL_IDLE = 2'b00;
    localparam logic [1:0] MUL_BUSY = 2'b01;
    localparam logic [1:0] MUL_DONE = 2'b10;

    typedef logic [63:0] double_reg_t;

    function automatic logic is_mult_op(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP);
    endfunction

endpackage

// File: rtl/ex_stage_mul_iter.sv
// Iterative shift-add 32x32 multiplier (IDLE -> BUSY x MUL_CYCLES -> DONE).
// Instantiated by ex_stage only when EX_MUL_EN is defined.
module mul_iter
    import ex_stage_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        signed_i,
    output logic        busy,
    output logic        done,
    output logic [63:0] result
);

    localparam int CW = $clog2(MUL_CYCLES);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    double_reg_t   acc;
    double_reg_t   mcand;
    logic [31:0]   mplier;
    logic          neg;
    logic [31:0]   mag1;
    logic [31:0]   mag2;

    // Multiply magnitudes; the sign is reapplied to the finished product.
    assign mag1 = (signed_i && op1[31]) ? -op1 : op1;
    assign mag2 = (signed_i && op2[31]) ? -op2 : op2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= MUL_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        mcand  <= {32'b0, mag1};
                        mplier <= mag2;
                        acc    <= '0;
                        neg    <= signed_i & (op1[31] ^ op2[31]);
                        cnt    <= '0;
                        state  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(MUL_CYCLES - 1)) begin
                        state <= MUL_DONE;
                    end
                end
                MUL_DONE: state <= MUL_IDLE;
                default:  state <= MUL_IDLE;
            endcase
        end
    end

    assign busy   = (state == MUL_BUSY);
    assign done   = (state == MUL_DONE);
    assign result = neg ? -acc : acc;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: logic/shift/move results, HI/LO registers, and (with EX_MUL_EN
// defined) MULT/MULTU on the iterative multiplier with a pipeline stall request.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] logic_res;
    logic [31:0] shift_res;
    logic [31:0] move_res;
    logic        mul_wr;
    double_reg_t mul_result;

    always_comb begin
        logic_res = 32'b0;
        case (aluop_i)
            EXE_OR_OP:  logic_res = reg1_i | reg2_i;
            EXE_AND_OP: logic_res = reg1_i & reg2_i;
            EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
            EXE_LUI_OP: logic_res = reg2_i;
            default:    logic_res = 32'b0;
        endcase
    end

    always_comb begin
        shift_res = 32'b0;
        case (aluop_i)
            EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
            EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
            EXE_SRA_OP: shift_res = 32'($signed(reg2_i) >>> reg1_i[4:0]);
            default:    shift_res = 32'b0;
        endcase
    end

    // MOVN/MOVZ only forward reg1; ID already decided whether the write happens.
    always_comb begin
        move_res = 32'b0;
        case (aluop_i)
            EXE_MFHI_OP: move_res = hi;
            EXE_MFLO_OP: move_res = lo;
            EXE_MOVN_OP: move_res = reg1_i;
            EXE_MOVZ_OP: move_res = reg1_i;
            default:     move_res = 32'b0;
        endcase
    end

    always_comb begin
        wdata_o = 32'b0;
        if (!rst) begin
            case (alusel_i)
                EXE_RES_LOGIC: wdata_o = logic_res;
                EXE_RES_SHIFT: wdata_o = shift_res;
                EXE_RES_MOVE:  wdata_o = move_res;
                default:       wdata_o = 32'b0;
            endcase
        end
    end

    assign wd_o   = rst ? 5'b0 : wd_i;
    assign wreg_o = rst ? 1'b0 : wreg_i;

`ifdef EX_MUL_EN
    logic mul_busy;
    logic mul_done;
    logic mul_start;

    assign mul_start = is_mult_op(aluop_i);

    mul_iter #(
        .MUL_CYCLES(MUL_CYCLES)
    ) u_mul_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (mul_start),
        .op1      (reg1_i),
        .op2      (reg2_i),
        .signed_i (aluop_i == EXE_MULT_OP),
        .busy     (mul_busy),
        .done     (mul_done),
        .result   (mul_result)
    );

    // A MULT still sitting on the inputs during DONE must not re-raise the stall.
    assign stallreq_o = ~rst & (mul_busy | (mul_start & ~mul_done));
    assign mul_wr     = mul_done;
`else
    assign stallreq_o = 1'b0;
    assign mul_wr     = 1'b0;
    assign mul_result = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= 32'b0;
            lo <= 32'b0;
        end else if (mul_wr) begin
            hi <= mul_result[63:32];
            lo <= mul_result[31:0];
        end else begin
            if (aluop_i == EXE_MTHI_OP) begin
                hi <= reg1_i;
            end
            if (aluop_i == EXE_MTLO_OP) begin
                lo <= reg1_i;
            end
        end
    end

    assign hi_o = hi;
    assign lo_o = lo;

endmodule

// File: tb/tb_ex_stage.sv
// Directed scoreboard bench for ex_stage; multiplier steps run only when EX_MUL_EN is defined,
// otherwise MULTU is checked to behave as a NOP.
module tb_ex_stage;
    import ex_stage_pkg::*;

    localparam int K_WDATA = 0;
    localparam int K_HI    = 1;
    localparam int K_LO    = 2;
    localparam int K_WD    = 3;
    localparam int K_WREG  = 4;
    localparam int K_STALL = 5;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq_o;

    exp_t        sbQ[$];
    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [31:0] modelHi     = 32'b0;
    logic [31:0] modelLo     = 32'b0;

    ex_stage #(.MUL_CYCLES(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .alusel_i   (alusel_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [7:0] op, input logic [2:0] sel,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [4:0] wd, input logic wreg);
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = r1;
        reg2_i   = r2;
        wd_i     = wd;
        wreg_i   = wreg;
    endtask

    task automatic expectOut(input string name, input int kind, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        sbQ.push_back(e);
    endtask

    task automatic check32(input string name, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h, expected %h", name, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            case (e.kind)
                K_WDATA: obs = wdata_o;
                K_HI:    obs = hi_o;
                K_LO:    obs = lo_o;
                K_WD:    obs = {27'b0, wd_o};
                K_WREG:  obs = {31'b0, wreg_o};
                K_STALL: obs = {31'b0, stallreq_o};
                default: obs = 'x;
            endcase
            check32(e.name, obs, e.exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One combinational step: drive, then compare at the following negedge.
    task automatic aluStep(input string name, input logic [7:0] op, input logic [2:0] sel,
                           input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] exp);
        applyStimulus(op, sel, r1, r2, 5'd9, 1'b1);
        expectOut(name, K_WDATA, exp);
        @(negedge clk);
        checkOutput();
        nextCycle();
    endtask

`ifdef EX_MUL_EN
    task automatic doMult(input string name, input logic [7:0] op,
                          input logic [31:0] r1, input logic [31:0] r2);
        logic [63:0] prod;
        int          stallCycles;
        if (op == EXE_MULT_OP)
            prod = $signed({{32{r1[31]}}, r1}) * $signed({{32{r2[31]}}, r2});
        else
            prod = {32'b0, r1} * {32'b0, r2};
        applyStimulus(op, EXE_RES_NOP, r1, r2, 5'd0, 1'b0);
        stallCycles = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stallreq_o !== 1'b1) break;
            stallCycles++;
            nextCycle();
        end
        check32({name, "_stall_cycles"}, stallCycles, 32'd33);
        expectOut({name, "_done_hi_old"}, K_HI, modelHi);
        expectOut({name, "_done_wdata"}, K_WDATA, 32'b0);
        expectOut({name, "_done_wreg"}, K_WREG, 32'd0);
        checkOutput();
        nextCycle();
        applyStimulus(EXE_NOP_OP, EXE_RES_NOP, 32'b0, 32'b0, 5'd0, 1'b0);
        modelHi = prod[63:32];
        modelLo = prod[31:0];
        expectOut({name, "_hi"}, K_HI, modelHi);
        expectOut({name, "_lo"}, K_LO, modelLo);
        expectOut({name, "_stall_after"}, K_STALL, 32'd0);
        @(negedge clk);
        checkOutput();
        nextCycle();
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000F0F0, 32'h00000F0F, 5'd3, 1'b1);
        #2;
        expectOut("rst_wdata", K_WDATA, 32'b0);
        expectOut("rst_wd", K_WD, 32'd0);
        expectOut("rst_wreg", K_WREG, 32'd0);
        expectOut("rst_hi", K_HI, 32'b0);
        expectOut("rst_lo", K_LO, 32'b0);
        expectOut("rst_stall", K_STALL, 32'd0);
        @(negedge clk);
        checkOutput();
        nextCycle();
        rst = 1'b0;

        applyStimulus(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000F0F0, 32'h00000F0F, 5'd7, 1'b1);
        expectOut("ori_wdata", K_WDATA, 32'h0000FFFF);
        expectOut("ori_wd", K_WD, 32'd7);
        expectOut("ori_wreg", K_WREG, 32'd1);
        @(negedge clk);
        checkOutput();
        nextCycle();

        aluStep("and", EXE_AND_OP, EXE_RES_LOGIC, 32'hA5A5A5A5, 32'h0FF00FF0, 32'h05A005A0);
        aluStep("xor", EXE_XOR_OP, EXE_RES_LOGIC, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F);
        aluStep("nor", EXE_NOR_OP, EXE_RES_LOGIC, 32'h0F0F0000, 32'h00000F0F, 32'hF0F0F0F0);
        aluStep("lui", EXE_LUI_OP, EXE_RES_LOGIC, 32'h0000FFFF, 32'h12340000, 32'h12340000);
        aluStep("sra", EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h80000000, 32'hF8000000);
        aluStep("srl", EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h80000000, 32'h08000000);
        aluStep("sll_amt5", EXE_SLL_OP, EXE_RES_SHIFT, 32'h00000023, 32'h00000001, 32'h00000008);
        aluStep("movn", EXE_MOVN_OP, EXE_RES_MOVE, 32'hCAFEBABE, 32'h11111111, 32'hCAFEBABE);
        aluStep("res_nop", EXE_OR_OP, EXE_RES_NOP, 32'hFFFFFFFF, 32'h1, 32'h0);
        aluStep("res_unlisted", EXE_OR_OP, 3'b111, 32'hFFFFFFFF, 32'h1, 32'h0);

        applyStimulus(EXE_MTHI_OP, EXE_RES_NOP, 32'h12345678, 32'h0, 5'd0, 1'b0);
        expectOut("mthi_wreg", K_WREG, 32'd0);
        expectOut("mthi_hi_before_edge", K_HI, modelHi);
        @(negedge clk);
        checkOutput();
        nextCycle();
        modelHi = 32'h12345678;
        applyStimulus(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd4, 1'b1);
        expectOut("mfhi_wdata", K_WDATA, modelHi);
        expectOut("mfhi_hi", K_HI, modelHi);
        @(negedge clk);
        checkOutput();
        nextCycle();

        applyStimulus(EXE_MTLO_OP, EXE_RES_NOP, 32'h9ABCDEF0, 32'h0, 5'd0, 1'b0);
        nextCycle();
        modelLo = 32'h9ABCDEF0;
        applyStimulus(EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd4, 1'b1);
        expectOut("mflo_wdata", K_WDATA, modelLo);
        expectOut("mflo_hi_kept", K_HI, modelHi);
        @(negedge clk);
        checkOutput();
        nextCycle();

`ifdef EX_MUL_EN
        doMult("mult_neg1x5", EXE_MULT_OP, 32'hFFFFFFFF, 32'd5);
        doMult("multu_ffx5", EXE_MULTU_OP, 32'hFFFFFFFF, 32'd5);

        applyStimulus(EXE_MULT_OP, EXE_RES_NOP, 32'd7, 32'd3, 5'd0, 1'b0);
        repeat (11) nextCycle();
        expectOut("abort_stall_busy", K_STALL, 32'd1);
        checkOutput();
        rst = 1'b1;
        #1;
        modelHi = 32'b0;
        modelLo = 32'b0;
        expectOut("abort_stall", K_STALL, 32'd0);
        expectOut("abort_hi", K_HI, modelHi);
        expectOut("abort_lo", K_LO, modelLo);
        checkOutput();
        applyStimulus(EXE_NOP_OP, EXE_RES_NOP, 32'b0, 32'b0, 5'd0, 1'b0);
        nextCycle();
        rst = 1'b0;
        nextCycle();
        doMult("mult_after_abort", EXE_MULT_OP, 32'd7, 32'hFFFFFFFD);
`else
        applyStimulus(EXE_MULTU_OP, EXE_RES_NOP, 32'd3, 32'd4, 5'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            expectOut("nomul_stall", K_STALL, 32'd0);
            expectOut("nomul_wdata", K_WDATA, 32'b0);
            @(negedge clk);
            checkOutput();
            nextCycle();
        end
        applyStimulus(EXE_NOP_OP, EXE_RES_NOP, 32'b0, 32'b0, 5'd0, 1'b0);
        expectOut("nomul_hi", K_HI, modelHi);
        expectOut("nomul_lo", K_LO, modelLo);
        @(negedge clk);
        checkOutput();
        nextCycle();
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
